fir_ram_feeder: RTL and testbench

Rate-adapting input/output stage wrapped around the RAM-based FIR core. Accepts a bursty valid/ready sample stream, buffers it in a small FIFO, and issues single-cycle sample strobes to the filter no closer together than the filter's per-sample compute time. After each strobe it captures the finished filter result and error flags and presents them as a one-cycle output pulse. Every accepted input sample yields exactly one output sample.

---
 rtl/fir_ram_feeder_if.sv | 29 ++
 rtl/fir_ram_feeder.sv | 106 ++++++++++
 tb/tb_fir_ram_feeder.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_ram_feeder_if.sv
// Stream, filter-side and result signals of the FIR rate-adapting feeder.
// The feeder takes the slave view; the surrounding logic takes the master view.
interface fir_ram_feeder_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int OUT_WIDTH     = 16,
  parameter int ERR_CNT_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] s_data_i;
  logic                         s_valid_i;
  logic                         s_ready_o;
  logic signed [DATA_WIDTH-1:0] fir_data_o;
  logic                         fir_val_o;
  logic signed [OUT_WIDTH-1:0]  fir_result_i;
  logic [1:0]                   fir_err_i;
  logic signed [OUT_WIDTH-1:0]  m_data_o;
  logic [1:0]                   m_err_o;
  logic                         m_valid_o;
  logic [ERR_CNT_WIDTH-1:0]     err_cnt_o;

  modport slave (
    input  s_data_i, s_valid_i, fir_result_i, fir_err_i,
    output s_ready_o, fir_data_o, fir_val_o, m_data_o, m_err_o, m_valid_o, err_cnt_o
  );

  modport master (
    output s_data_i, s_valid_i, fir_result_i, fir_err_i,
    input  s_ready_o, fir_data_o, fir_val_o, m_data_o, m_err_o, m_valid_o, err_cnt_o
  );
endinterface

// File: rtl/fir_ram_feeder.sv
// Buffers a bursty sample stream, paces single-cycle strobes into the RAM-based
// FIR core no closer than MIN_GAP cycles, and captures each finished result.
module fir_ram_feeder #(
  parameter int DATA_WIDTH    = 16,
  parameter int OUT_WIDTH     = 16,
  parameter int FILTER_ORDER  = 256,
  parameter int PARALLEL      = 1,
  parameter int MIN_GAP       = FILTER_ORDER / PARALLEL + 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  fir_ram_feeder_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(MIN_GAP);

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count, count_nxt;
  logic                         s_ready_p1;
  logic                         push_p0, pop_p0, cap_p0;
  logic [GW-1:0]                gap_cnt;
  logic                         pending;

  logic                         fir_vld_p1;
  logic signed [DATA_WIDTH-1:0] fir_data_p1;
  logic                         m_vld_p1;
  logic signed [OUT_WIDTH-1:0]  m_data_p1;
  logic [1:0]                   m_err_p1;
  logic [ERR_CNT_WIDTH-1:0]     err_cnt_p2;

  // p0: handshake, pop and capture decisions
  always_comb begin
    push_p0   = bus.s_valid_i && s_ready_p1;
    pop_p0    = (count != '0) && (gap_cnt == '0);
    cap_p0    = pending && (gap_cnt == '0);
    count_nxt = count + CW'(push_p0) - CW'(pop_p0);
  end

  always_ff @(posedge clk_i) begin
    if (push_p0) mem[wr_ptr] <= bus.s_data_i;
  end

  // p1: FIFO bookkeeping, filter strobe and result capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      s_ready_p1  <= 1'b0;
      gap_cnt     <= '0;
      pending     <= 1'b0;
      fir_vld_p1  <= 1'b0;
      fir_data_p1 <= '0;
      m_vld_p1    <= 1'b0;
      m_data_p1   <= '0;
      m_err_p1    <= '0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + AW'(1);
      if (pop_p0)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      s_ready_p1 <= (count_nxt != CW'(FIFO_DEPTH));
      fir_vld_p1 <= pop_p0;
      if (pop_p0) fir_data_p1 <= mem[rd_ptr];

      if (pop_p0)                gap_cnt <= GW'(MIN_GAP - 1);
      else if (gap_cnt != '0)    gap_cnt <= gap_cnt - GW'(1);

      // A capture sharing a cycle with the next pop still leaves one capture pending.
      if (pop_p0)      pending <= 1'b1;
      else if (cap_p0) pending <= 1'b0;

      m_vld_p1 <= cap_p0;
      if (cap_p0) begin
        m_data_p1 <= bus.fir_result_i;
        m_err_p1  <= bus.fir_err_i;
      end
    end
  end

  // p2: error statistics on presented results
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_p2 <= '0;
    end else if (m_vld_p1 && (m_err_p1 != 2'b00)) begin
      err_cnt_p2 <= sat_inc(err_cnt_p2);
    end
  end

  assign bus.s_ready_o  = s_ready_p1;
  assign bus.fir_val_o  = fir_vld_p1;
  assign bus.fir_data_o = fir_data_p1;
  assign bus.m_valid_o  = m_vld_p1;
  assign bus.m_data_o   = m_data_p1;
  assign bus.m_err_o    = m_err_p1;
  assign bus.err_cnt_o  = err_cnt_p2;

endmodule

// File: tb/tb_fir_ram_feeder.sv
// Bench for fir_ram_feeder: two instances (MIN_GAP=4 and MIN_GAP=2) driven by
// directed and random phases, checked every cycle against a timing-rule model.
module tb_fir_ram_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic        rst_n [2];
  logic        svalid[2];
  logic [15:0] sdata [2];
  logic [15:0] fres  [2];
  logic [1:0]  ferr  [2];
  logic        fval  [2];
  logic        rdy   [2];
  logic        mv    [2];
  logic [15:0] fdata [2];
  logic [15:0] md    [2];
  logic [1:0]  me    [2];
  logic [15:0] ecnt  [2];

  fir_ram_feeder_if #(.DATA_WIDTH(16), .OUT_WIDTH(16), .ERR_CNT_WIDTH(2))  bus_a();
  fir_ram_feeder_if #(.DATA_WIDTH(16), .OUT_WIDTH(16), .ERR_CNT_WIDTH(16)) bus_b();

  assign bus_a.s_data_i     = sdata[0];
  assign bus_a.s_valid_i    = svalid[0];
  assign bus_a.fir_result_i = fres[0];
  assign bus_a.fir_err_i    = ferr[0];
  assign fval[0]  = bus_a.fir_val_o;
  assign rdy[0]   = bus_a.s_ready_o;
  assign mv[0]    = bus_a.m_valid_o;
  assign fdata[0] = bus_a.fir_data_o;
  assign md[0]    = bus_a.m_data_o;
  assign me[0]    = bus_a.m_err_o;
  assign ecnt[0]  = {14'd0, bus_a.err_cnt_o};

  assign bus_b.s_data_i     = sdata[1];
  assign bus_b.s_valid_i    = svalid[1];
  assign bus_b.fir_result_i = fres[1];
  assign bus_b.fir_err_i    = ferr[1];
  assign fval[1]  = bus_b.fir_val_o;
  assign rdy[1]   = bus_b.s_ready_o;
  assign mv[1]    = bus_b.m_valid_o;
  assign fdata[1] = bus_b.fir_data_o;
  assign md[1]    = bus_b.m_data_o;
  assign me[1]    = bus_b.m_err_o;
  assign ecnt[1]  = bus_b.err_cnt_o;

  fir_ram_feeder #(.DATA_WIDTH(16), .OUT_WIDTH(16), .MIN_GAP(4), .FIFO_DEPTH(4),
                   .ERR_CNT_WIDTH(2)) dut_a (.clk_i(clk), .rst_n_i(rst_n[0]), .bus(bus_a));
  fir_ram_feeder #(.DATA_WIDTH(16), .OUT_WIDTH(16), .MIN_GAP(2), .FIFO_DEPTH(4),
                   .ERR_CNT_WIDTH(16)) dut_b (.clk_i(clk), .rst_n_i(rst_n[1]), .bus(bus_b));

  // Stub filter: after each strobe it presents a result (and error flags) from the next cycle.
  int          err_mode[2];
  int          err_k0  [2];
  int          stub_k  [2];
  logic        sv      [2];
  logic [15:0] sd      [2];

  always begin
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      sv[g] = fval[g];
      sd[g] = fdata[g];
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      if (sv[g]) begin
        int rel;
        stub_k[g] = stub_k[g] + 1;
        rel = stub_k[g] - err_k0[g];
        if (err_mode[g] == 3) begin
          fres[g] = 16'($urandom);
          ferr[g] = 2'($urandom);
        end else begin
          fres[g] = sd[g] + 16'h0ACB;
          case (err_mode[g])
            1:       ferr[g] = (rel == 2 || rel == 4) ? 2'b01 : 2'b00;
            2:       ferr[g] = 2'b10;
            default: ferr[g] = 2'b00;
          endcase
        end
      end
    end
  end

  task automatic chk(input int g, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed %0h expected %0h at cycle %0d", tag, g, obs, exp, cyc);
    end
  endtask

  // Reference: a sample strobes at the earliest cycle that is >= its acceptance + 2
  // and >= previous strobe + MIN_GAP; its result appears MIN_GAP cycles after the strobe.
  int          qd[2][64], qa[2][64], qh[2], qt[2];
  int          mvq[2][64], mh[2], mt[2];
  int          last_st[2];
  logic [15:0] prev_res[2];
  logic [1:0]  prev_err[2];
  logic [15:0] e_fd[2], e_md[2];
  logic [1:0]  e_me[2];
  int          e_cnt[2];
  bit          inc_next[2], was_rst[2];
  int          pulses[2], accepted[2];

  task automatic model_step(input int g);
    int mgap, emax;
    bit ev, emv, erdy;
    mgap = (g == 0) ? 4 : 2;
    emax = (g == 0) ? 3 : 65535;
    ev = 1'b0; emv = 1'b0; erdy = 1'b0;
    if (!rst_n[g]) begin
      qh[g] = 0; qt[g] = 0; mh[g] = 0; mt[g] = 0;
      last_st[g] = -1000;
      e_fd[g] = '0; e_md[g] = '0; e_me[g] = '0; e_cnt[g] = 0;
      inc_next[g] = 1'b0;
      was_rst[g] = 1'b1;
    end else begin
      if (inc_next[g]) begin
        if (e_cnt[g] < emax) e_cnt[g]++;
        inc_next[g] = 1'b0;
      end
      ev = (qt[g] > qh[g]) && (qa[g][qh[g] % 64] <= cyc - 2) && (cyc >= last_st[g] + mgap);
      if (ev) begin
        e_fd[g] = 16'(qd[g][qh[g] % 64]);
        qh[g]++;
        last_st[g] = cyc;
        mvq[g][mt[g] % 64] = cyc + mgap;
        mt[g]++;
      end
      emv = (mt[g] > mh[g]) && (mvq[g][mh[g] % 64] == cyc);
      if (emv) begin
        e_md[g] = prev_res[g];
        e_me[g] = prev_err[g];
        mh[g]++;
        if (prev_err[g] != 2'b00) inc_next[g] = 1'b1;
      end
      erdy = !was_rst[g] && ((qt[g] - qh[g]) < 4);
      was_rst[g] = 1'b0;
      if (svalid[g] && erdy) begin
        qd[g][qt[g] % 64] = int'(sdata[g]);
        qa[g][qt[g] % 64] = cyc;
        qt[g]++;
        accepted[g]++;
      end
    end
    prev_res[g] = fres[g];
    prev_err[g] = ferr[g];
    if (mv[g] === 1'b1) pulses[g]++;
    chk(g, "fir_val",   32'(fval[g]),  32'(ev));
    chk(g, "fir_data",  32'(fdata[g]), 32'(e_fd[g]));
    chk(g, "s_ready",   32'(rdy[g]),   32'(erdy));
    chk(g, "m_valid",   32'(mv[g]),    32'(emv));
    chk(g, "m_data",    32'(md[g]),    32'(e_md[g]));
    chk(g, "m_err",     32'(me[g]),    32'(e_me[g]));
    chk(g, "err_cnt",   32'(ecnt[g]),  32'(e_cnt[g]));
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) model_step(g);
  end

  bit saw_bp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [15:0] d, output int acc_cyc);
    int n;
    n = 0;
    svalid[g] = 1'b1;
    sdata[g]  = d;
    while (rdy[g] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n > 0) saw_bp = 1'b1;
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout[%0d]: observed no s_ready_o, required s_ready_o=1 within 200 cycles", g);
    end
    acc_cyc = cyc;
    tick();
  endtask

  task automatic wait_strobe(input int g, output int t);
    int n;
    n = 0;
    while (fval[g] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $error("FAIL strobe_timeout[%0d]: observed no fir_val_o, required a strobe within 100 cycles", g);
    end
    t = cyc;
  endtask

  task automatic wait_pulse(input int g, output int t);
    int n;
    n = 0;
    while (mv[g] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $error("FAIL pulse_timeout[%0d]: observed no m_valid_o, required a pulse within 100 cycles", g);
    end
    t = cyc;
  endtask

  initial begin
    int a_c, t_c, p_c, p0;
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; svalid[g] = 1'b0; sdata[g] = '0;
      fres[g] = '0; ferr[g] = '0;
      err_mode[g] = 0; err_k0[g] = 0; stub_k[g] = 0;
    end
    repeat (3) tick();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (3) tick();

    // single sample: strobe 2 cycles after acceptance, result MIN_GAP cycles later
    send(0, 16'h0123, a_c);
    svalid[0] = 1'b0;
    wait_strobe(0, t_c);
    chk(0, "p1_strobe_lat", 32'(t_c - a_c), 32'd2);
    chk(0, "p1_fir_data", 32'(fdata[0]), 32'h0123);
    wait_pulse(0, p_c);
    chk(0, "p1_result_lat", 32'(p_c - t_c), 32'd4);
    chk(0, "p1_m_data", 32'(md[0]), 32'h0BEE);
    repeat (4) tick();

    // burst 1..6 with errors on the 2nd and 4th results
    err_k0[0] = stub_k[0];
    err_mode[0] = 1;
    p0 = pulses[0];
    saw_bp = 1'b0;
    for (int i = 1; i <= 6; i++) send(0, 16'(i), a_c);
    svalid[0] = 1'b0;
    repeat (40) tick();
    chk(0, "p2_pulses", 32'(pulses[0] - p0), 32'd6);
    chk(0, "p2_backpressure", 32'(saw_bp), 32'd1);
    chk(0, "p2_err_cnt", 32'(ecnt[0]), 32'd2);

    // five errored results drive the 2-bit counter into saturation
    err_mode[0] = 2;
    p0 = pulses[0];
    for (int i = 0; i < 5; i++) send(0, 16'(16'h0100 + i), a_c);
    svalid[0] = 1'b0;
    repeat (40) tick();
    chk(0, "p3_pulses", 32'(pulses[0] - p0), 32'd5);
    chk(0, "p3_err_sat", 32'(ecnt[0]), 32'd3);

    // reset one cycle after a strobe with three samples still queued
    err_mode[0] = 0;
    for (int i = 0; i < 5; i++) send(0, 16'(16'h0200 + i), a_c);
    svalid[0] = 1'b0;
    wait_strobe(0, t_c);
    tick();
    rst_n[0] = 1'b0;
    p0 = pulses[0];
    tick();
    rst_n[0] = 1'b1;
    repeat (15) tick();
    chk(0, "p4_no_pulse", 32'(pulses[0] - p0), 32'd0);
    chk(0, "p4_err_cnt", 32'(ecnt[0]), 32'd0);
    send(0, 16'h0055, a_c);
    svalid[0] = 1'b0;
    wait_strobe(0, t_c);
    chk(0, "p4_strobe_lat", 32'(t_c - a_c), 32'd2);
    chk(0, "p4_fir_data", 32'(fdata[0]), 32'h0055);
    repeat (10) tick();

    // random traffic and random filter responses
    err_mode[0] = 3;
    for (int i = 0; i < 200; i++) begin
      svalid[0] = 1'($urandom_range(0, 1));
      sdata[0]  = 16'($urandom);
      tick();
    end
    svalid[0] = 1'b0;
    repeat (30) tick();

    // MIN_GAP=2: continuous input, capture and next strobe share cycles
    err_mode[1] = 3;
    p0 = pulses[1];
    for (int i = 0; i < 40; i++) send(1, 16'($urandom), a_c);
    svalid[1] = 1'b0;
    repeat (20) tick();
    chk(1, "p6_pulses", 32'(pulses[1] - p0), 32'd40);
    chk(1, "p6_all_results", 32'(pulses[1]), 32'(accepted[1]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
